clint_axil: RTL and testbench
=============================

Name: clint_axil

Overview:
Parametrised core-local interruptor: a multi-hart successor to the read-only mtime CLINT.
- Full AXI4-Lite slave with read and write channels.
- Prescaled 64-bit mtime; per-hart mtimecmp and msip registers.
- Registered timer (mtip) and software (msip) interrupt outputs.
- Sits on the SoC peripheral crossbar next to the core(s); interrupt outputs feed each hart's CSR/mip logic.

Parameters:
NUM_HARTS, 1, number of harts (1..16); one msip and one mtimecmp per hart
TICK_DIV, 1, core clocks per mtime increment (>=1); 1 = every cycle
ADDR_W, 16, decoded address bits; upper address bits are ignored

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_awaddr  in  32  write address
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_bresp  out  2  write response
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_araddr  in  32  read address
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
mtip  out  NUM_HARTS  timer interrupt pending, one bit per hart
msip  out  NUM_HARTS  software interrupt pending, one bit per hart

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Address map (offset = addr[ADDR_W-1:0]):
  - msip[h] at 0x0000+4h; bit0 is the value, other bits read 0.
  - mtimecmp[h] lo/hi at 0x4000+8h / 0x4004+8h.
  - mtime lo/hi at 0xBFF8 / 0xBFFC.
  - Any other offset, or h>=NUM_HARTS, is unmapped.
- Reset values:
  - mtime=0, mtimecmp=all-ones, msip=0, mtip=0.
  - arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - Prescaler count=0.
- Timebase: prescaler counts 0..TICK_DIV-1; mtime increments when count==TICK_DIV-1. mtime wraps from 2^64-1 to 0.
- Read FSM, states R_IDLE and R_RESP:
  - arready=1 only in R_IDLE, registered; it is 1 from the first cycle after reset deassertion.
  - On an AR handshake at cycle N, rdata is loaded with the register value at cycle N. rvalid=1 from N+1.
  - rvalid, rdata and rresp are held stable until rready; the FSM then returns to R_IDLE with arready=1 the following cycle.
  - Unmapped read: rdata=0, rresp=2'b10 (SLVERR). Mapped read: rresp=2'b00.
- Write FSM, states W_IDLE, W_EXEC and W_RESP:
  - In W_IDLE, AW and W are accepted independently. awready=1 until the address is captured; wready=1 until the data and strobes are captured.
  - Once both are captured the FSM enters W_EXEC. The register is updated on that clock edge, then the FSM enters W_RESP.
  - bvalid=1 in W_RESP and is held until bready; the FSM then returns to W_IDLE.
  - Unmapped write: no state change, bresp=2'b10.
- Simultaneous events:
  - A write to mtime in the same cycle as a tick: the write wins and the tick is lost. The prescaler keeps running.
  - A read and a write in the same cycle are independent; the read returns the pre-write value.
- Interrupts, registered with 1-cycle latency from register state:
  - mtip[h] <= (mtime >= mtimecmp[h]), 64-bit unsigned compare.
  - msip[h] is driven directly by msip register bit0.
- Reset mid-transaction: in-flight AR/AW/W/response are dropped and all valids/readies return to their reset values next cycle.
- 64-bit registers are written as independent 32-bit halves; there is no atomicity.

Optional Feature:
CLINT_WSTRB_EN
- Defined: wstrb applies byte-granular writes to every mapped register.
- Undefined: wstrb is ignored and every write is full-word.
- bresp behaviour is identical in both builds.

Decomposition:
- Package clint_pkg holds:
  - offset constants: MSIP_BASE, MTIMECMP_BASE, MTIME_LO, MTIME_HI;
  - RESP_OKAY and RESP_SLVERR;
  - read and write FSM state enums.
- Sub-module clint_timebase (prescaler plus 64-bit mtime with a load port) is natural; decode and the FSMs remain in clint_axil.

Test Plan:
- Reset, TICK_DIV=1, single AR to 0xBFF8 with rready held high -> rvalid=1 one cycle after the handshake, rresp=0, rdata equals the elapsed cycles since reset.
- TICK_DIV=4: read mtime lo twice, 40 cycles apart -> difference is 10.
- NUM_HARTS=2: write mtimecmp[1] hi=0 then lo=0x20 -> mtip[1] rises in the cycle after mtime reaches 0x20; mtip[0] stays 0.
- Write 1 to 0x0004, W presented 3 cycles before AW -> bresp=0, msip=2'b10; write 0 -> msip=2'b00.
- Read 0x1234 and write 0x8000 -> rresp=2'b10 with rdata=0; bresp=2'b10; no register changes.
- Hold rready=0 and bready=0 for 5 cycles -> rvalid and bvalid stay high with stable data; no new AR or AW is accepted; assert rst mid-wait -> all valids are 0 next cycle.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared offsets, response codes, FSM states and decode helpers for clint_axil.
// Build option CLINT_WSTRB_EN enables byte-granular writes in clint_merge.
package clint_pkg;

    localparam logic [31:0] MSIP_BASE     = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_BASE = 32'h0000_4000;
    localparam logic [31:0] MTIME_LO      = 32'h0000_BFF8;
    localparam logic [31:0] MTIME_HI      = 32'h0000_BFFC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {RIdle, RResp} r_state_e;
    typedef enum logic [1:0] {WIdle, WExec, WResp} w_state_e;

    typedef enum logic [2:0] {
        RegNone, RegMsip, RegCmpLo, RegCmpHi, RegTimeLo, RegTimeHi
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [3:0] hart;
    } reg_dec_t;

    // Offset must be word-aligned and hart-indexed registers must exist.
    function automatic reg_dec_t clint_decode(input logic [31:0] off,
                                              input int unsigned num_harts);
        reg_dec_t d;
        d.sel  = RegNone;
        d.hart = '0;
        if (off == MTIME_LO) begin
            d.sel = RegTimeLo;
        end else if (off == MTIME_HI) begin
            d.sel = RegTimeHi;
        end else begin
            for (int unsigned h = 0; h < 16; h++) begin
                if (h < num_harts) begin
                    if (off == MSIP_BASE + 32'(4 * h)) begin
                        d.sel  = RegMsip;
                        d.hart = 4'(h);
                    end
                    if (off == MTIMECMP_BASE + 32'(8 * h)) begin
                        d.sel  = RegCmpLo;
                        d.hart = 4'(h);
                    end
                    if (off == MTIMECMP_BASE + 32'(8 * h + 4)) begin
                        d.sel  = RegCmpHi;
                        d.hart = 4'(h);
                    end
                end
            end
        end
        return d;
    endfunction

    function automatic logic [31:0] clint_reg_value(input reg_sel_e sel, input logic msip_bit,
                                                    input logic [63:0] cmp,
                                                    input logic [63:0] mtime);
        case (sel)
            RegMsip:   return {31'b0, msip_bit};
            RegCmpLo:  return cmp[31:0];
            RegCmpHi:  return cmp[63:32];
            RegTimeLo: return mtime[31:0];
            RegTimeHi: return mtime[63:32];
            default:   return '0;
        endcase
    endfunction

    function automatic logic [31:0] clint_merge(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] r;
`ifdef CLINT_WSTRB_EN
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
        end
`else
        r = wdata;
`endif
        return r;
    endfunction

endpackage

// File: rtl/clint_timebase.sv
// Prescaler plus free-running 64-bit mtime; a load overrides the same-cycle tick.
module clint_timebase #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [63:0] load_val_i,
    output logic [63:0] mtime_o
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     mtime_q, mtime_d;
    logic            tick;

    assign tick = (cnt_q == CntMax);

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        mtime_d = mtime_q;
        if (load_i) begin
            mtime_d = load_val_i;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            mtime_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/clint_axil.sv
// Multi-hart CLINT on an AXI4-Lite slave: msip, mtimecmp and prescaled mtime.
// Define CLINT_WSTRB_EN for byte-granular register writes.
module clint_axil
    import clint_pkg::*;
#(
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [31:0]          s_axi_awaddr,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    input  logic [31:0]          s_axi_wdata,
    input  logic [3:0]           s_axi_wstrb,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    output logic [1:0]           s_axi_bresp,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    input  logic [31:0]          s_axi_araddr,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    output logic [31:0]          s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] msip
);

    r_state_e r_state_q, r_state_d;
    w_state_e w_state_q, w_state_d;
    logic arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d, bresp_q, bresp_d;
    logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic [NUM_HARTS-1:0]       msip_q, msip_d, mtip_q, mtip_d;
    logic [NUM_HARTS-1:0][63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] mtime, tb_load_val, ar_cmp, aw_cmp;
    logic        tb_load, wr_en, ar_msip, aw_msip;
    logic [31:0] rd_val, wr_old, wr_new;
    reg_dec_t    ar_dec, aw_dec;
    logic        unused_bits;

    assign unused_bits = ^{s_axi_awaddr, s_axi_araddr};

    clint_timebase #(.TICK_DIV(TICK_DIV)) u_timebase (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tb_load),
        .load_val_i(tb_load_val),
        .mtime_o   (mtime)
    );

    assign ar_dec = clint_decode(32'(s_axi_araddr[ADDR_W-1:0]), NUM_HARTS);
    assign aw_dec = clint_decode(32'(awaddr_q), NUM_HARTS);

    always_comb begin
        ar_cmp  = '1;
        ar_msip = 1'b0;
        aw_cmp  = '1;
        aw_msip = 1'b0;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (ar_dec.hart == 4'(h)) begin
                ar_cmp  = mtimecmp_q[h];
                ar_msip = msip_q[h];
            end
            if (aw_dec.hart == 4'(h)) begin
                aw_cmp  = mtimecmp_q[h];
                aw_msip = msip_q[h];
            end
        end
    end

    assign rd_val = clint_reg_value(ar_dec.sel, ar_msip, ar_cmp, mtime);
    assign wr_old = clint_reg_value(aw_dec.sel, aw_msip, aw_cmp, mtime);
    assign wr_new = clint_merge(wr_old, wdata_q, wstrb_q);

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            RIdle: begin
                arready_d = 1'b1;
                if (s_axi_arvalid && arready_q) begin
                    r_state_d = RResp;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_val;
                    rresp_d   = (ar_dec.sel == RegNone) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            RResp: begin
                if (s_axi_rready) begin
                    r_state_d = RIdle;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wr_en     = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                if (s_axi_awvalid && awready_q) begin
                    awaddr_d  = s_axi_awaddr[ADDR_W-1:0];
                    aw_have_d = 1'b1;
                end
                if (s_axi_wvalid && wready_q) begin
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                    w_have_d = 1'b1;
                end
                awready_d = !aw_have_d;
                wready_d  = !w_have_d;
                if (aw_have_d && w_have_d) begin
                    w_state_d = WExec;
                end
            end
            WExec: begin
                wr_en     = 1'b1;
                w_state_d = WResp;
                bvalid_d  = 1'b1;
                bresp_d   = (aw_dec.sel == RegNone) ? RESP_SLVERR : RESP_OKAY;
            end
            WResp: begin
                if (s_axi_bready) begin
                    w_state_d = WIdle;
                    bvalid_d  = 1'b0;
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        msip_d      = msip_q;
        mtimecmp_d  = mtimecmp_q;
        tb_load     = 1'b0;
        tb_load_val = mtime;
        if (wr_en) begin
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                if (aw_dec.hart == 4'(h)) begin
                    if (aw_dec.sel == RegMsip)  msip_d[h] = wr_new[0];
                    if (aw_dec.sel == RegCmpLo) mtimecmp_d[h][31:0] = wr_new;
                    if (aw_dec.sel == RegCmpHi) mtimecmp_d[h][63:32] = wr_new;
                end
            end
            if (aw_dec.sel == RegTimeLo) begin
                tb_load           = 1'b1;
                tb_load_val[31:0] = wr_new;
            end
            if (aw_dec.sel == RegTimeHi) begin
                tb_load            = 1'b1;
                tb_load_val[63:32] = wr_new;
            end
        end
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            mtip_d[h] = (mtime >= mtimecmp_q[h]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= WIdle;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msip_q     <= '0;
            mtip_q     <= '0;
            mtimecmp_q <= '1;
        end else begin
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign mtip          = mtip_q;
    assign msip          = msip_q;

endmodule

// File: tb/tb_clint_axil.sv
// Self-checking bench: a 2-hart TICK_DIV=1 instance driven by a vector table and
// scoreboard, plus a 1-hart TICK_DIV=4 instance for the prescaler rate.
module tb_clint_axil;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 1;
    logic        s_axi_arvalid = 0, s_axi_rready = 1;
    logic [31:0] s_axi_awaddr = 0, s_axi_wdata = 0, s_axi_araddr = 0;
    logic [3:0]  s_axi_wstrb = 4'hF;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic [1:0]  mtip, msip;

    logic        ar4_valid = 0, rready4 = 1;
    logic [31:0] ar4_addr = 0;
    logic        ar4_ready, r4_valid, aw4_ready, w4_ready, b4_valid;
    logic [31:0] r4_data;
    logic [1:0]  r4_resp, b4_resp;
    logic [0:0]  mtip4, msip4;

    clint_axil #(.NUM_HARTS(2), .TICK_DIV(1), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .mtip(mtip), .msip(msip)
    );

    clint_axil #(.NUM_HARTS(1), .TICK_DIV(4), .ADDR_W(16)) dut4 (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(1'b0), .s_axi_awready(aw4_ready), .s_axi_awaddr(32'h0),
        .s_axi_wvalid(1'b0), .s_axi_wready(w4_ready), .s_axi_wdata(32'h0),
        .s_axi_wstrb(4'h0), .s_axi_bvalid(b4_valid), .s_axi_bready(1'b1),
        .s_axi_bresp(b4_resp), .s_axi_arvalid(ar4_valid), .s_axi_arready(ar4_ready),
        .s_axi_araddr(ar4_addr), .s_axi_rvalid(r4_valid), .s_axi_rready(rready4),
        .s_axi_rdata(r4_data), .s_axi_rresp(r4_resp), .mtip(mtip4), .msip(msip4)
    );

`ifdef CLINT_WSTRB_EN
    localparam logic [31:0] StrbExp = 32'h1122_33DD;
`else
    localparam logic [31:0] StrbExp = 32'hAABB_CCDD;
`endif

    typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;
    typedef struct {
        string name; bit is_wr; logic [31:0] addr; logic [31:0] data;
        logic [3:0] strb; logic [31:0] exp; logic [1:0] resp;
    } vec_t;

    rsp_t rd_q[$];
    rsp_t wr_q[$];
    vec_t vecs[$];
    int   n_vec = 0, n_err = 0, cyc = 0;
    logic [63:0] mt_model = 0;

    // Reference mtime for the TICK_DIV=1 instance, valid until mtime is written.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mt_model <= rst ? 64'd0 : mt_model + 64'd1;
    end

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input string name, input bit is_wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb,
                                input logic [31:0] exp, input logic [1:0] resp);
        vec_t v;
        v.name = name; v.is_wr = is_wr; v.addr = addr; v.data = data;
        v.strb = strb; v.exp = exp; v.resp = resp;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid,
              s_axi_bvalid, s_axi_rresp, s_axi_bresp, mtip, msip, s_axi_rdata, ar4_ready},
              64'h0);
        rst = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input bit use_mtime,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp,
                            input string name);
        rsp_t e;
        int   n = 0;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
        check({name, "_arready"}, s_axi_arready, 1);
        e.data = use_mtime ? mt_model[31:0] : exp_data;
        e.resp = exp_resp;
        rd_q.push_back(e);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check({name, "_rvalid_lat"}, s_axi_rvalid, 1);
        n = 0;
        while (!s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
        if (s_axi_rvalid) begin
            e = rd_q.pop_front();
            check({name, "_rdata"}, s_axi_rdata, e.data);
            check({name, "_rresp"}, s_axi_rresp, e.resp);
        end
        @(negedge clk);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp,
                             input int w_lead, input string name);
        rsp_t e;
        int   n = 0, lead = w_lead;
        logic aw_pend = 1'b1, w_pend = 1'b1, aw_go, w_go;
        e.data = '0;
        e.resp = exp_resp;
        wr_q.push_back(e);
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        while ((aw_pend || w_pend) && n < 30) begin
            if (lead == 0 && aw_pend) s_axi_awvalid = 1'b1;
            aw_go = s_axi_awvalid && s_axi_awready;
            w_go  = s_axi_wvalid && s_axi_wready;
            @(negedge clk);
            n++;
            if (lead > 0) lead--;
            if (aw_go) begin aw_pend = 1'b0; s_axi_awvalid = 1'b0; end
            if (w_go)  begin w_pend  = 1'b0; s_axi_wvalid  = 1'b0; end
            if (w_lead > 0 && n == 1)
                check({name, "_w_first_ready"}, {s_axi_awready, s_axi_wready}, 2'b10);
        end
        check({name, "_handshake"}, {aw_pend, w_pend}, 2'b00);
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
        check({name, "_bvalid"}, s_axi_bvalid, 1);
        if (s_axi_bvalid) begin
            e = wr_q.pop_front();
            check({name, "_bresp"}, s_axi_bresp, e.resp);
        end
        @(negedge clk);
    endtask

    task automatic read4(output logic [31:0] d, output int t);
        int n = 0;
        while (!ar4_ready && n < 20) begin @(negedge clk); n++; end
        check("tick4_arready", ar4_ready, 1);
        t = cyc;
        ar4_addr  = 32'hBFF8;
        ar4_valid = 1'b1;
        @(negedge clk);
        ar4_valid = 1'b0;
        n = 0;
        while (!r4_valid && n < 20) begin @(negedge clk); n++; end
        check("tick4_rvalid", r4_valid, 1);
        d = r4_data;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d0, d1;
        int t0, t1, n;

        @(negedge clk);
        do_reset();
        axi_read(32'hBFF8, 1'b1, 32'h0, 2'b00, "mtime_lo");
        axi_read(32'hBFFC, 1'b0, 32'h0, 2'b00, "mtime_hi");

        read4(d0, t0);
        while (cyc < t0 + 40) @(negedge clk);
        read4(d1, t1);
        check("tick4_delta", d1 - d0, 32'd10);

        do_reset();
        axi_write(32'h400C, 32'h0, 4'hF, 2'b00, 0, "cmp1_hi");
        axi_write(32'h4008, 32'h20, 4'hF, 2'b00, 0, "cmp1_lo");
        check("mtip1_before", mtip[1], 0);
        n = 0;
        while (!mtip[1] && n < 100) begin @(negedge clk); n++; end
        check("mtip1_rise", mtip[1], 1);
        check("mtip1_time", mt_model, 64'h21);
        check("mtip0_low", mtip[0], 0);

        axi_write(32'h0004, 32'h1, 4'hF, 2'b00, 3, "msip1_set");
        check("msip_set", msip, 2'b10);
        axi_write(32'h0004, 32'h0, 4'hF, 2'b00, 0, "msip1_clr");
        check("msip_clr", msip, 2'b00);

        vecs.push_back(mk("msip1_wr_ones", 1, 32'h0004, 32'hFFFF_FFFF, 4'hF, 0, 2'b00));
        vecs.push_back(mk("msip1_rd",      0, 32'h0004, 0, 0, 32'h1, 2'b00));
        vecs.push_back(mk("msip1_alias",   0, 32'h1_0004, 0, 0, 32'h1, 2'b00));
        vecs.push_back(mk("msip0_rd",      0, 32'h0000, 0, 0, 32'h0, 2'b00));
        vecs.push_back(mk("cmp0_lo_wr",    1, 32'h4000, 32'h1122_3344, 4'hF, 0, 2'b00));
        vecs.push_back(mk("cmp0_lo_rd",    0, 32'h4000, 0, 0, 32'h1122_3344, 2'b00));
        vecs.push_back(mk("cmp0_hi_rd",    0, 32'h4004, 0, 0, 32'hFFFF_FFFF, 2'b00));
        vecs.push_back(mk("cmp1_lo_rd",    0, 32'h4008, 0, 0, 32'h20, 2'b00));
        vecs.push_back(mk("cmp1_hi_rd",    0, 32'h400C, 0, 0, 32'h0, 2'b00));
        vecs.push_back(mk("cmp0_strb_wr",  1, 32'h4000, 32'hAABB_CCDD, 4'h1, 0, 2'b00));
        vecs.push_back(mk("cmp0_strb_rd",  0, 32'h4000, 0, 0, StrbExp, 2'b00));
        vecs.push_back(mk("cmp2_unmapped", 0, 32'h4010, 0, 0, 32'h0, 2'b10));
        vecs.push_back(mk("msip2_unmapped",0, 32'h0008, 0, 0, 32'h0, 2'b10));
        vecs.push_back(mk("rd_1234",       0, 32'h1234, 0, 0, 32'h0, 2'b10));
        vecs.push_back(mk("rd_unaligned",  0, 32'h0002, 0, 0, 32'h0, 2'b10));
        vecs.push_back(mk("wr_8000",       1, 32'h8000, 32'hFFFF_FFFF, 4'hF, 0, 2'b10));
        vecs.push_back(mk("cmp0_after_bad",0, 32'h4000, 0, 0, StrbExp, 2'b00));
        vecs.push_back(mk("msip1_after_bad",0,32'h0004, 0, 0, 32'h1, 2'b00));
        vecs.push_back(mk("msip1_wr0",     1, 32'h0004, 32'h0, 4'hF, 0, 2'b00));
        vecs.push_back(mk("msip1_rd0",     0, 32'h0004, 0, 0, 32'h0, 2'b00));
        vecs.push_back(mk("mtime_hi_wr",   1, 32'hBFFC, 32'h5, 4'hF, 0, 2'b00));
        vecs.push_back(mk("mtime_hi_rd",   0, 32'hBFFC, 0, 0, 32'h5, 2'b00));

        foreach (vecs[i]) begin
            if (vecs[i].is_wr)
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, 0,
                          vecs[i].name);
            else
                axi_read(vecs[i].addr, 1'b0, vecs[i].exp, vecs[i].resp, vecs[i].name);
        end

        // Back-pressure: both responses held, new requests must not be accepted.
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        check("hold_ready", {s_axi_arready, s_axi_awready, s_axi_wready}, 3'b111);
        s_axi_araddr = 32'h4000; s_axi_arvalid = 1'b1;
        s_axi_awaddr = 32'h0004; s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_araddr = 32'hBFF8; s_axi_awaddr = 32'h0000; s_axi_wvalid = 1'b0;
        check("hold_r_first", {s_axi_rvalid, s_axi_bvalid, s_axi_rdata}, {2'b10, StrbExp});
        @(negedge clk);
        check("hold_b_first", {s_axi_bvalid, msip}, 3'b110);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_stable", {s_axi_rvalid, s_axi_bvalid, s_axi_arready, s_axi_awready,
                  s_axi_rresp, s_axi_bresp, msip, s_axi_rdata},
                  {4'b1100, 2'b00, 2'b00, 2'b10, StrbExp});
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset", {s_axi_rvalid, s_axi_bvalid, s_axi_arready, s_axi_awready,
              s_axi_wready, msip}, 7'b0);
        rst = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
